// File: rtl/aes_sequencer.sv
// Sequences one AES-128 core: key expansion, delayed start, ciphertext capture,
// scope trigger and hung-core timeout, with sticky error reporting.
module aes_sequencer #(
  parameter int unsigned GO_DELAY = 255,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_key,
  input  logic [127:0] key,
  input  logic         load_pt,
  input  logic [127:0] pt,
  input  logic         do_enc,
  output logic [127:0] core_key,
  output logic         core_key_load,
  input  logic         core_key_ready,
  output logic [127:0] core_pt,
  output logic         core_start,
  input  logic [127:0] core_ct,
  input  logic         core_done,
  output logic [127:0] ct,
  output logic         ct_ready,
  output logic         trigger,
  output logic         busy,
  output logic         key_valid,
  output logic [1:0]   err,
  output logic [2:0]   dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KEYEXP = 3'd1,
    ARMED  = 3'd2,
    RUN    = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [15:0] GO_LOAD  = 16'(GO_DELAY - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t        state_q;
  logic [127:0]  key_q, pt_q, ct_q;
  logic          key_load_q, start_q, key_valid_q;
  logic [1:0]    err_q;
  logic [15:0]   cnt_q, tmo_q;
  logic          key_accept;

  // A new key is accepted whenever the core is not mid-encryption.
  assign key_accept = load_key && (state_q == IDLE || state_q == KEYEXP || state_q == ARMED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      key_q       <= '0;
      pt_q        <= '0;
      ct_q        <= '0;
      key_load_q  <= 1'b0;
      start_q     <= 1'b0;
      key_valid_q <= 1'b0;
      err_q       <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
    end else begin
      key_load_q <= 1'b0;
      start_q    <= 1'b0;
      if (key_accept) begin
        // A plaintext arriving alongside the key is dropped and flagged.
        key_q       <= key;
        key_valid_q <= 1'b0;
        err_q       <= {load_pt, 1'b0};
        key_load_q  <= 1'b1;
        tmo_q       <= '0;
        state_q     <= KEYEXP;
      end else begin
        case (state_q)
          IDLE: begin
            if (load_pt) begin
              if (key_valid_q) begin
                pt_q <= pt;
                if (GO_DELAY <= 1) begin
                  start_q <= 1'b1;
                  tmo_q   <= '0;
                  state_q <= RUN;
                end else begin
                  cnt_q   <= GO_LOAD;
                  state_q <= ARMED;
                end
              end else begin
                err_q[1] <= 1'b1;
              end
            end
          end
          KEYEXP: begin
            if (load_pt) err_q[1] <= 1'b1;
            if (core_key_ready) begin
              key_valid_q <= 1'b1;
              state_q     <= IDLE;
            end else if (tmo_q >= TMO_LAST) begin
              err_q[0] <= 1'b1;
              state_q  <= IDLE;
            end else if (tmo_q != 16'hFFFF) begin
              tmo_q <= tmo_q + 16'd1;
            end
          end
          ARMED: begin
            // Leaving on count 1 lands core_start exactly GO_DELAY cycles after load_pt.
            if (load_pt) begin
              pt_q  <= pt;
              cnt_q <= GO_LOAD;
            end else if (do_enc || cnt_q <= 16'd1) begin
              start_q <= 1'b1;
              tmo_q   <= '0;
              state_q <= RUN;
            end else begin
              cnt_q <= cnt_q - 16'd1;
            end
          end
          RUN: begin
            if (load_key || load_pt) err_q[1] <= 1'b1;
            if (core_done) begin
              ct_q    <= core_ct;
              state_q <= DONE;
            end else if (tmo_q >= TMO_LAST) begin
              err_q[0] <= 1'b1;
              state_q  <= IDLE;
            end else if (tmo_q != 16'hFFFF) begin
              tmo_q <= tmo_q + 16'd1;
            end
          end
          DONE: begin
            if (load_key || load_pt) err_q[1] <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign core_key      = key_q;
  assign core_key_load = key_load_q;
  assign core_pt       = pt_q;
  assign core_start    = start_q;
  assign ct            = ct_q;
  assign ct_ready      = (state_q == DONE);
  assign trigger       = (state_q == RUN);
  assign busy          = (state_q != IDLE);
  assign key_valid     = key_valid_q;
  assign err           = err_q;
  assign dbg_state     = state_q;

endmodule
